// File: rtl/msg_buffer_scheduler_if.sv
// Bus bundle between msg_buffer_scheduler and its buffers, Wishbone slave and injection port.
// Defaults for the packet geometry macros; the codebase's global defines override them.
`ifndef MAX_PACKET_LENGHT
`define MAX_PACKET_LENGHT 2
`endif
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 16
`endif

interface msg_buffer_scheduler_if #(
  parameter int N_BUFFERS        = 4,
  parameter int N_BITS_BUFFER_ID = 2,
  parameter int N_VNETS          = 3,
  parameter int N_BITS_VNET_ID   = 2,
  parameter int PKT_W            = `MAX_PACKET_LENGHT * `FLIT_WIDTH
);
  // Handshakes: a chunk moves when chunk_valid_i & accept_o in the same cycle;
  // a packet moves when pkt_valid_o & pkt_ack_i in the same cycle. Neither
  // valid may depend combinationally on its own ready/ack.
  logic                                  chunk_valid_i;
  logic                                  accept_o;
  logic [N_BUFFERS-1:0]                  buf_wr_o;
  logic [N_BUFFERS-1:0]                  buf_is_valid_i;
  logic [N_BUFFERS*N_BITS_VNET_ID-1:0]   buf_vnet_id_i;
  logic [N_BUFFERS-1:0]                  buf_clear_o;
  logic [N_BUFFERS*PKT_W-1:0]            bufs_pkt_i;
  logic [N_VNETS-1:0]                    vnet_free_i;
  logic                                  pkt_valid_o;
  logic [PKT_W-1:0]                      pkt_o;
  logic [N_BITS_VNET_ID-1:0]             vnet_id_o;
  logic [N_BITS_BUFFER_ID-1:0]           send_id_o;
  logic                                  pkt_ack_i;
  logic [0:0]                            dbg_send_state_o;

  modport master (
    input  chunk_valid_i, buf_is_valid_i, buf_vnet_id_i, bufs_pkt_i, vnet_free_i, pkt_ack_i,
    output accept_o, buf_wr_o, buf_clear_o, pkt_valid_o, pkt_o, vnet_id_o, send_id_o,
    output dbg_send_state_o
  );

  modport slave (
    output chunk_valid_i, buf_is_valid_i, buf_vnet_id_i, bufs_pkt_i, vnet_free_i, pkt_ack_i,
    input  accept_o, buf_wr_o, buf_clear_o, pkt_valid_o, pkt_o, vnet_id_o, send_id_o,
    input  dbg_send_state_o
  );
endinterface

// File: rtl/msg_buffer_scheduler.sv
// Allocates message buffers for filling from the bus and grants completed ones
// to the injection port round-robin, gated per virtual network.
`ifndef MAX_PACKET_LENGHT
`define MAX_PACKET_LENGHT 2
`endif
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 16
`endif

module msg_buffer_scheduler #(
  parameter int N_BUFFERS        = 4,
  parameter int N_BITS_BUFFER_ID = 2,
  parameter int N_VNETS          = 3,
  parameter int N_BITS_VNET_ID   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  msg_buffer_scheduler_if.master bus
);
  localparam int PKT_W = `MAX_PACKET_LENGHT * `FLIT_WIDTH;
  localparam int IDW   = N_BITS_BUFFER_ID;
  localparam int VW    = N_BITS_VNET_ID;

  localparam logic [1:0] B_FREE    = 2'd0;
  localparam logic [1:0] B_FILLING = 2'd1;
  localparam logic [1:0] B_READY   = 2'd2;
  localparam logic [1:0] B_SENDING = 2'd3;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [1:0]           buf_state [N_BUFFERS];
  logic                 fill_valid;
  logic [IDW-1:0]       fill_ptr;
  logic [0:0]           send_state;
  logic [IDW-1:0]       send_id;
  logic [IDW-1:0]       rr_ptr;

  logic                 alloc_found;
  logic [IDW-1:0]       alloc_idx;
  logic [N_BUFFERS-1:0] eligible;
  logic                 grant_found;
  logic [IDW-1:0]       grant_idx;
  int                   cand;
  logic                 accept;
  logic                 fill_done;
  logic                 sending;
  logic                 ack_take;

  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    for (int i = N_BUFFERS - 1; i >= 0; i--) begin
      if (buf_state[i] == B_FREE) begin
        alloc_found = 1'b1;
        alloc_idx   = IDW'(i);
      end
    end
  end

  // A vnet id outside 0..N_VNETS-1 never matches, so such a buffer is never eligible.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_BUFFERS; i++) begin
      for (int v = 0; v < N_VNETS; v++) begin
        if (buf_state[i] == B_READY && bus.buf_vnet_id_i[i*VW +: VW] == VW'(v) &&
            bus.vnet_free_i[v])
          eligible[i] = 1'b1;
      end
    end
  end

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 1; k <= N_BUFFERS; k++) begin
      cand = (int'(rr_ptr) + k) % N_BUFFERS;
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(cand);
      end
    end
  end

  assign accept    = fill_valid & ~bus.buf_is_valid_i[fill_ptr];
  assign fill_done = fill_valid &  bus.buf_is_valid_i[fill_ptr];
  assign sending   = (send_state == S_SEND);
  assign ack_take  = sending & bus.pkt_ack_i;

  always_comb begin
    bus.buf_wr_o    = '0;
    bus.buf_clear_o = '0;
    if (bus.chunk_valid_i && accept) bus.buf_wr_o[fill_ptr] = 1'b1;
    if (ack_take)                    bus.buf_clear_o[send_id] = 1'b1;
  end

  assign bus.accept_o         = accept;
  assign bus.pkt_valid_o      = sending;
  assign bus.send_id_o        = send_id;
  assign bus.pkt_o            = sending ? bus.bufs_pkt_i[int'(send_id)*PKT_W +: PKT_W] : '0;
  assign bus.vnet_id_o        = sending ? bus.buf_vnet_id_i[int'(send_id)*VW +: VW] : '0;
  assign bus.dbg_send_state_o = send_state;

  // Fill and send paths never touch the same buffer: one works on FREE/FILLING,
  // the other on READY/SENDING.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_BUFFERS; i++) buf_state[i] <= B_FREE;
      fill_valid <= 1'b0;
      fill_ptr   <= '0;
      send_state <= S_IDLE;
      send_id    <= '0;
      rr_ptr     <= IDW'(N_BUFFERS - 1);
    end else begin
      if (fill_done) begin
        buf_state[fill_ptr] <= B_READY;
        fill_valid          <= 1'b0;
      end else if (!fill_valid && alloc_found) begin
        buf_state[alloc_idx] <= B_FILLING;
        fill_ptr             <= alloc_idx;
        fill_valid           <= 1'b1;
      end

      case (send_state)
        S_IDLE: begin
          if (grant_found) begin
            buf_state[grant_idx] <= B_SENDING;
            send_id              <= grant_idx;
            send_state           <= S_SEND;
          end
        end
        default: begin
          if (bus.pkt_ack_i) begin
            buf_state[send_id] <= B_FREE;
            rr_ptr             <= send_id;
            send_state         <= S_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_msg_buffer_scheduler.sv
// Directed bench for msg_buffer_scheduler with a behavioural model of four
// one-chunk message buffers.
`ifndef MAX_PACKET_LENGHT
`define MAX_PACKET_LENGHT 2
`endif
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 16
`endif

module tb_msg_buffer_scheduler;
  localparam int NB    = 4;
  localparam int PKT_W = `MAX_PACKET_LENGHT * `FLIT_WIDTH;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  msg_buffer_scheduler_if #(
    .N_BUFFERS(NB), .N_BITS_BUFFER_ID(2), .N_VNETS(3), .N_BITS_VNET_ID(2)
  ) bus ();

  msg_buffer_scheduler #(
    .N_BUFFERS(NB), .N_BITS_BUFFER_ID(2), .N_VNETS(3), .N_BITS_VNET_ID(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // buffer model: any write completes a one-chunk packet, clear empties it
  logic [NB-1:0]    m_valid;
  logic [1:0]       m_vnet [NB];
  logic [PKT_W-1:0] m_pkt  [NB];
  int               wr_cnt [NB];
  logic [1:0]       cur_vnet;
  logic [PKT_W-1:0] cur_data;

  always @(posedge clk) begin
    if (rst) begin
      m_valid <= '0;
      for (int i = 0; i < NB; i++) begin
        m_vnet[i] <= '0;
        m_pkt[i]  <= '0;
        wr_cnt[i] <= 0;
      end
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (bus.buf_wr_o[i]) begin
          m_valid[i] <= 1'b1;
          m_vnet[i]  <= cur_vnet;
          m_pkt[i]   <= cur_data;
          wr_cnt[i]  <= wr_cnt[i] + 1;
        end else if (bus.buf_clear_o[i]) begin
          m_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    bus.buf_is_valid_i = m_valid;
    for (int i = 0; i < NB; i++) begin
      bus.buf_vnet_id_i[i*2 +: 2]      = m_vnet[i];
      bus.bufs_pkt_i[i*PKT_W +: PKT_W] = m_pkt[i];
    end
  end

  // scoreboard
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
  endtask

  // driver tasks
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_accept"},    64'(bus.accept_o),    64'd0);
    check({tag, "_buf_wr"},    64'(bus.buf_wr_o),    64'd0);
    check({tag, "_buf_clear"}, 64'(bus.buf_clear_o), 64'd0);
    check({tag, "_pkt_valid"}, 64'(bus.pkt_valid_o), 64'd0);
    check({tag, "_send_id"},   64'(bus.send_id_o),   64'd0);
    check({tag, "_vnet_id"},   64'(bus.vnet_id_o),   64'd0);
    check({tag, "_pkt"},       64'(bus.pkt_o),       64'd0);
  endtask

  task automatic do_reset(input string tag);
    rst               = 1'b1;
    bus.chunk_valid_i = 1'b0;
    bus.pkt_ack_i     = 1'b0;
    bus.vnet_free_i   = 3'b000;
    step();
    step();
    check_idle_outputs({tag, "_rst"});
    rst = 1'b0;
  endtask

  task automatic write_chunk(input string tag, input logic [1:0] vnet,
                             input logic [PKT_W-1:0] data, input int exp_idx);
    for (int n = 0; n < 40 && !bus.accept_o; n++) step();
    check({tag, "_accept"}, 64'(bus.accept_o), 64'd1);
    bus.chunk_valid_i = 1'b1;
    cur_vnet          = vnet;
    cur_data          = data;
    #1;
    check({tag, "_buf_wr"}, 64'(bus.buf_wr_o), 64'(4'b0001 << exp_idx));
    step();
    bus.chunk_valid_i = 1'b0;
  endtask

  task automatic wait_grant(input string tag, input int exp_id, input logic [1:0] exp_vnet,
                            input logic [PKT_W-1:0] exp_pkt);
    for (int n = 0; n < 40 && !bus.pkt_valid_o; n++) step();
    check({tag, "_pkt_valid"}, 64'(bus.pkt_valid_o), 64'd1);
    check({tag, "_send_id"},   64'(bus.send_id_o),   64'(exp_id));
    check({tag, "_vnet_id"},   64'(bus.vnet_id_o),   64'(exp_vnet));
    check({tag, "_pkt"},       64'(bus.pkt_o),       64'(exp_pkt));
  endtask

  task automatic do_ack(input string tag, input int exp_id);
    bus.pkt_ack_i = 1'b1;
    #1;
    check({tag, "_clear"}, 64'(bus.buf_clear_o), 64'(4'b0001 << exp_id));
    step();
    bus.pkt_ack_i = 1'b0;
    #1;
    check({tag, "_clear_done"}, 64'(bus.buf_clear_o), 64'd0);
    check({tag, "_valid_gap"},  64'(bus.pkt_valid_o), 64'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst               = 1'b1;
    bus.chunk_valid_i = 1'b0;
    bus.pkt_ack_i     = 1'b0;
    bus.vnet_free_i   = 3'b000;
    cur_vnet          = '0;
    cur_data          = '0;

    // single HEAD_TAIL message, exact latencies
    do_reset("s1");
    bus.vnet_free_i = 3'b111;
    step();
    check("s1_first_accept", 64'(bus.accept_o), 64'd1);
    bus.chunk_valid_i = 1'b1;
    cur_vnet          = 2'd1;
    cur_data          = 32'h1111_0001;
    #1;
    check("s1_buf_wr", 64'(bus.buf_wr_o), 64'h1);
    step();
    bus.chunk_valid_i = 1'b0;
    #1;
    check("s1_accept_gap1", 64'(bus.accept_o), 64'd0);
    step();
    check("s1_valid_early", 64'(bus.pkt_valid_o), 64'd0);
    check("s1_accept_gap2", 64'(bus.accept_o), 64'd0);
    step();
    check("s1_pkt_valid", 64'(bus.pkt_valid_o), 64'd1);
    check("s1_send_id",   64'(bus.send_id_o),   64'd0);
    check("s1_vnet_id",   64'(bus.vnet_id_o),   64'd1);
    check("s1_pkt",       64'(bus.pkt_o),       64'h1111_0001);
    do_ack("s1_ack0", 0);
    write_chunk("s1_w1", 2'd1, 32'h1111_0002, 1);
    write_chunk("s1_w0", 2'd1, 32'h1111_0003, 0);
    wait_grant("s1_g1", 1, 2'd1, 32'h1111_0002);
    do_ack("s1_ack1", 1);
    wait_grant("s1_g0", 0, 2'd1, 32'h1111_0003);
    do_ack("s1_ack0b", 0);

    // fill every buffer with nothing downstream free
    do_reset("s2");
    for (int i = 0; i < NB; i++) write_chunk("s2_fill", 2'd0, PKT_W'(32'h2222_0000 + i), i);
    for (int n = 0; n < 4; n++) step();
    check("s2_full_accept", 64'(bus.accept_o), 64'd0);
    bus.vnet_free_i = 3'b111;
    wait_grant("s2_g0", 0, 2'd0, 32'h2222_0000);
    do_ack("s2_ack0", 0);
    check("s2_accept_t1", 64'(bus.accept_o), 64'd0);
    step();
    check("s2_accept_t2", 64'(bus.accept_o), 64'd1);
    write_chunk("s2_refill", 2'd0, 32'h2222_0010, 0);

    // round-robin order and wrap of the pointer
    do_reset("s3");
    write_chunk("s3_w0", 2'd0, 32'h3333_0000, 0);
    write_chunk("s3_w1", 2'd1, 32'h3333_0001, 1);
    write_chunk("s3_w2", 2'd0, 32'h3333_0002, 2);
    bus.vnet_free_i = 3'b011;
    wait_grant("s3_g0", 0, 2'd0, 32'h3333_0000);
    do_ack("s3_a0", 0);
    wait_grant("s3_g1", 1, 2'd1, 32'h3333_0001);
    do_ack("s3_a1", 1);
    wait_grant("s3_g2", 2, 2'd0, 32'h3333_0002);
    bus.vnet_free_i = 3'b000;
    do_ack("s3_a2", 2);
    write_chunk("s3_w3", 2'd2, 32'h3333_0003, 3);
    write_chunk("s3_r0", 2'd0, 32'h3333_0010, 0);
    write_chunk("s3_r1", 2'd1, 32'h3333_0011, 1);
    bus.vnet_free_i = 3'b011;
    wait_grant("s3_wrap", 0, 2'd0, 32'h3333_0010);
    do_ack("s3_a0b", 0);
    wait_grant("s3_g1b", 1, 2'd1, 32'h3333_0011);
    do_ack("s3_a1b", 1);

    // per-vnet gating
    do_reset("s4");
    write_chunk("s4_w0", 2'd2, 32'h4444_0000, 0);
    write_chunk("s4_w1", 2'd0, 32'h4444_0001, 1);
    bus.vnet_free_i = 3'b001;
    wait_grant("s4_g1", 1, 2'd0, 32'h4444_0001);
    do_ack("s4_a1", 1);
    for (int n = 0; n < 3; n++) step();
    check("s4_blocked", 64'(bus.pkt_valid_o), 64'd0);
    bus.vnet_free_i = 3'b101;
    wait_grant("s4_g0", 0, 2'd2, 32'h4444_0000);
    do_ack("s4_a0", 0);

    // reset in the middle of a send
    do_reset("s5");
    write_chunk("s5_w0", 2'd0, 32'h5555_0000, 0);
    write_chunk("s5_w1", 2'd0, 32'h5555_0001, 1);
    bus.vnet_free_i = 3'b001;
    wait_grant("s5_g0", 0, 2'd0, 32'h5555_0000);
    rst = 1'b1;
    #1;
    check("s5_no_clear", 64'(bus.buf_clear_o), 64'd0);
    step();
    check_idle_outputs("s5_mid");
    rst = 1'b0;
    step();
    check("s5_accept_after", 64'(bus.accept_o), 64'd1);
    write_chunk("s5_w0b", 2'd0, 32'h5555_0010, 0);

    // chunk_valid held across a completion
    do_reset("s6");
    step();
    check("s6_accept", 64'(bus.accept_o), 64'd1);
    bus.chunk_valid_i = 1'b1;
    cur_vnet          = 2'd0;
    cur_data          = 32'h6666_0000;
    #1;
    check("s6_wr0", 64'(bus.buf_wr_o), 64'h1);
    step();
    check("s6_gap1", 64'(bus.buf_wr_o), 64'd0);
    step();
    check("s6_gap2", 64'(bus.buf_wr_o), 64'd0);
    step();
    check("s6_wr1", 64'(bus.buf_wr_o), 64'h2);
    bus.chunk_valid_i = 1'b0;
    step();
    check("s6_buf0_writes", 64'(wr_cnt[0]), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/msg_buffer_scheduler.md
Name: msg_buffer_scheduler

Overview:
- Controls a pool of N_BUFFERS message_buffer instances between the Wishbone slave side and the network injection side.
- Allocates one free buffer at a time to receive bus chunks and steers each chunk's write strobe to that buffer.
- Marks a buffer ready when it reports a complete packet, then grants ready buffers to the injection port round-robin, gated per virtual network.
- Issues clear_buffer to the sent buffer on acknowledge, which returns it to the free pool.

Parameters:
- N_BUFFERS, 4, number of message_buffer instances managed (≥2).
- N_BITS_BUFFER_ID, 2, width of buffer index; 2^N_BITS_BUFFER_ID ≥ N_BUFFERS.
- N_VNETS, 3, number of virtual networks.
- N_BITS_VNET_ID, 2, width of vnet id (matches message_buffer).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- chunk_valid_i  in  1  Wishbone slave has a valid chunk (ADR/DAT/SEL) this cycle.
- accept_o  out  1  a filling buffer exists and can take a chunk this cycle.
- buf_wr_o  out  N_BUFFERS  one-hot is_valid_i strobe to the buffers.
- buf_is_valid_i  in  N_BUFFERS  is_valid_o of each buffer (packet complete).
- buf_vnet_id_i  in  N_BUFFERS*N_BITS_VNET_ID  vnet_id_o of each buffer, packed (buffer i at [i*W +: W]).
- buf_clear_o  out  N_BUFFERS  one-hot clear_buffer_i to the buffers.
- bufs_pkt_i  in  N_BUFFERS*`MAX_PACKET_LENGHT*`FLIT_WIDTH  pkt_o of each buffer, packed.
- vnet_free_i  in  N_VNETS  downstream can take a packet on vnet v.
- pkt_valid_o  out  1  packet offered to the injection port.
- pkt_o  out  `MAX_PACKET_LENGHT*`FLIT_WIDTH  packet of the granted buffer.
- vnet_id_o  out  N_BITS_VNET_ID  vnet of the offered packet.
- send_id_o  out  N_BITS_BUFFER_ID  index of the granted buffer.
- pkt_ack_i  in  1  injection port consumed the packet (valid only while pkt_valid_o).

Behaviour:
- Per-buffer state: FREE, FILLING, READY, SENDING. At most one buffer is FILLING and at most one is SENDING.
- Reset: all buffers FREE; fill_valid=0, rr_ptr=N_BUFFERS-1, send FSM IDLE.
  - Outputs during and after reset: accept_o=0, buf_wr_o=0, buf_clear_o=0, pkt_valid_o=0, send_id_o=0, vnet_id_o=0, pkt_o=0.
  - Reset mid-burst or mid-send discards all state; no clear pulse is issued (buffers self-reset on rst).
- Allocation:
  - If fill_valid=0 and any buffer is FREE, the lowest-index FREE buffer becomes FILLING at the next edge (fill_ptr, fill_valid=1).
  - The first accept is therefore 1 cycle after reset release.
- Fill:
  - accept_o = fill_valid & !buf_is_valid_i[fill_ptr].
  - buf_wr_o[fill_ptr] = chunk_valid_i & accept_o; all other bits are 0.
  - chunk_valid_i while accept_o=0 is not forwarded (the slave must stall).
- Completion:
  - When buf_is_valid_i[fill_ptr]=1 while FILLING, the buffer goes READY at the next edge and fill_valid clears.
  - A new buffer is allocated one edge later.
  - Net effect: accept_o is low for exactly 2 cycles between packets when a FREE buffer exists.
- Send FSM, IDLE:
  - Eligible = READY buffers i with vnet_free_i[buf_vnet_id_i[i]]=1.
  - Search round-robin starting at (rr_ptr+1) mod N_BUFFERS.
  - If a buffer is found, register send_id_o, mark it SENDING, and go to SEND; pkt_valid_o=1 from the next cycle.
- Send FSM, SEND:
  - pkt_valid_o=1; pkt_o and vnet_id_o are muxed combinationally from send_id_o.
  - vnet_free_i dropping after grant does not revoke the grant.
  - On pkt_ack_i=1: buf_clear_o[send_id_o]=1 in the same cycle (combinational, single cycle), rr_ptr<=send_id_o.
  - At the next edge the buffer becomes FREE and the FSM returns to IDLE; pkt_valid_o=0 for at least 1 cycle between packets.
- Simultaneous events: a buffer freed on pkt_ack may be allocated for filling at the very next edge (allocation sees FREE after the clear edge).
- All buffers non-FREE: accept_o stays 0 until a send completes.
- pkt_ack_i outside SEND is ignored.
- Invariant: buf_wr_o and buf_clear_o never target the same buffer in the same cycle.

Test Plan:
- Reset then single 1-chunk HEAD_TAIL message on buffer 0, vnet 1 free:
  - accept_o=1 at cycle 1, buf_wr_o=0001.
  - pkt_valid_o=1 with send_id_o=0, vnet_id_o=1.
  - ack -> buf_clear_o=0001 one cycle, then buffer 0 reallocatable.
- Fill all 4 buffers without ack:
  - buffers 0..3 fill in order; accept_o stays 0 after the 4th completes.
  - The first ack frees buffer 0 and accept_o=1 two cycles after the ack.
- Buffers 0,1,2 READY with vnets 0,1,0, vnet_free_i=011, three acks: grant order 0,1,2; then refill 0 and 1 -> next grant is 0 (rr_ptr=2 wraps).
- Buffers 0 (vnet 2) and 1 (vnet 0) READY, vnet_free_i=001: grant 1 only; buffer 0 granted once vnet_free_i[2] rises.
- Assert rst during SEND with 2 READY buffers: outputs 0 next cycle, no buf_clear_o pulse, first accept_o 1 cycle after release on buffer 0.
- chunk_valid_i held high across a completion: buf_wr_o=0 during the 2-cycle gap, and no chunk is written to the READY buffer.
